lane_data_memory: RTL and testbench

- Memory-side responder for the multicore processor's shared data-memory interface.
- Holds one data bank per core lane, all addressed by the single shared memory address and write enable.
- Returns the per-lane read data bus to the cores.
- A host port preloads operands before a run and reads results back after it; a small mode FSM arbitrates between host access and CPU run.

---
 rtl/lane_data_memory.sv | 100 ++++++++++
 tb/tb_lane_data_memory.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lane_data_memory.sv
// lane_data_memory: per-lane data banks shared by the core array, with a host preload/readback port
module lane_data_memory #(
    parameter int CORE_COUNT = 4,
    parameter int MEM_WIDTH  = 12,
    parameter int MEM_ADDR   = 12,
    parameter int DEPTH_LOG2 = 8,
    parameter int LANE_BITS  = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            done,
    input  logic [MEM_ADDR-1:0]             MemAddr,
    input  logic                            DataMemoryWriteEnable,
    input  logic [MEM_WIDTH*CORE_COUNT-1:0] ProcessorDataOut,
    output logic [MEM_WIDTH*CORE_COUNT-1:0] ProcessorDataIn,
    input  logic                            host_valid,
    input  logic                            host_write,
    input  logic [LANE_BITS-1:0]            host_lane,
    input  logic [DEPTH_LOG2-1:0]           host_addr,
    input  logic [MEM_WIDTH-1:0]            host_wdata,
    output logic                            host_ready,
    output logic [MEM_WIDTH-1:0]            host_rdata,
    output logic                            host_rvalid,
    output logic                            running,
    output logic [15:0]                     wr_count
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic {HOST, RUN} state_t;

    state_t                          state_q, state_d;
    logic [MEM_WIDTH-1:0]            mem [CORE_COUNT][DEPTH];
    logic [MEM_WIDTH*CORE_COUNT-1:0] pdi_q, pdi_d;
    logic [MEM_WIDTH-1:0]            rdata_q, rdata_d;
    logic                            rvalid_q, rvalid_d;
    logic [15:0]                     wr_count_q, wr_count_d;
    logic [DEPTH_LOG2-1:0]           cpu_addr;
    logic                            host_acc, cpu_wr;
    logic                            unused_addr_bits;

    assign cpu_addr         = MemAddr[DEPTH_LOG2-1:0];
    assign unused_addr_bits = ^MemAddr[MEM_ADDR-1:DEPTH_LOG2];
    assign host_ready       = state_q == HOST;
    assign host_acc         = host_valid && host_ready;
    assign cpu_wr           = state_q == RUN && DataMemoryWriteEnable;

    assign ProcessorDataIn = pdi_q;
    assign host_rdata      = rdata_q;
    assign host_rvalid     = rvalid_q;
    assign running         = state_q == RUN;
    assign wr_count        = wr_count_q;

    // next-state: mode FSM, registered reads for both ports, run write counter
    always_comb begin
        state_d = state_q == HOST ? (start ? RUN : HOST) : (done ? HOST : RUN);
        pdi_d   = pdi_q;
        rdata_d = rdata_q;
        for (int i = 0; i < CORE_COUNT; i++)
            if (state_q == RUN) pdi_d[MEM_WIDTH*i +: MEM_WIDTH] = mem[i][cpu_addr];
        if (host_acc && !host_write) begin
            rdata_d = '0;
            for (int i = 0; i < CORE_COUNT; i++)
                if (host_lane == LANE_BITS'(i)) rdata_d = mem[i][host_addr];
        end
        rvalid_d   = host_acc && !host_write;
        wr_count_d = (state_q == HOST && start) ? 16'd0 :
                     (cpu_wr && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
    end

    // control and output registers; bank contents live outside the reset domain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= HOST;
            pdi_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            pdi_q      <= pdi_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            wr_count_q <= wr_count_d;
        end
    end

    genvar b;
    generate
        for (b = 0; b < CORE_COUNT; b++) begin : g_bank
            // one bank per lane: CPU writes in RUN, host writes in HOST, never both
            always_ff @(posedge clock) begin
                if (cpu_wr)
                    mem[b][cpu_addr] <= ProcessorDataOut[MEM_WIDTH*b +: MEM_WIDTH];
                else if (host_acc && host_write && host_lane == LANE_BITS'(b))
                    mem[b][host_addr] <= host_wdata;
            end
        end
    endgenerate
endmodule

// File: tb/tb_lane_data_memory.sv
// tb_lane_data_memory: directed checks of the host port, CPU run access and the mode FSM
module tb_lane_data_memory;
    logic        clock = 0;
    logic        reset;
    logic        start, done, we;
    logic [11:0] mem_addr;
    logic [47:0] pdo, pdi;
    logic [35:0] pdi3;
    logic        host_valid, host_write;
    logic [1:0]  host_lane;
    logic [7:0]  host_addr;
    logic [11:0] host_wdata, rdata, rdata3;
    logic        ready, ready3, rvalid, rvalid3, running, running3;
    logic [15:0] wrc, wrc3;
    int          n_pass = 0, n_total = 0;

    always #5 clock = ~clock;

    lane_data_memory u_dut (
        .clock(clock), .reset(reset), .start(start), .done(done),
        .MemAddr(mem_addr), .DataMemoryWriteEnable(we),
        .ProcessorDataOut(pdo), .ProcessorDataIn(pdi),
        .host_valid(host_valid), .host_write(host_write), .host_lane(host_lane),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(ready), .host_rdata(rdata), .host_rvalid(rvalid),
        .running(running), .wr_count(wrc)
    );

    lane_data_memory #(.CORE_COUNT(3)) u_dut3 (
        .clock(clock), .reset(reset), .start(start), .done(done),
        .MemAddr(mem_addr), .DataMemoryWriteEnable(we),
        .ProcessorDataOut(pdo[35:0]), .ProcessorDataIn(pdi3),
        .host_valid(host_valid), .host_write(host_write), .host_lane(host_lane),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(ready3), .host_rdata(rdata3), .host_rvalid(rvalid3),
        .running(running3), .wr_count(wrc3)
    );

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hwrite(input logic [1:0] lane, input logic [7:0] addr, input logic [11:0] d);
        host_valid = 1; host_write = 1; host_lane = lane; host_addr = addr; host_wdata = d;
        tick();
        host_valid = 0; host_write = 0;
    endtask

    task automatic hread(input logic [1:0] lane, input logic [7:0] addr);
        host_valid = 1; host_write = 0; host_lane = lane; host_addr = addr;
        tick();
        host_valid = 0;
    endtask

    initial begin
        reset = 1; start = 0; done = 0; we = 0; mem_addr = 0; pdo = 0;
        host_valid = 0; host_write = 0; host_lane = 0; host_addr = 0; host_wdata = 0;
        #12;
        chk("rst_running", running, 0);
        chk("rst_wr_count", wrc, 0);
        chk("rst_pdi", pdi, 0);
        chk("rst_rdata_rvalid", {rdata, rvalid}, 0);
        chk("rst_ready", ready, 1);
        reset = 0;
        tick();

        hwrite(0, 5, 12'h111);
        hwrite(1, 5, 12'h222);
        hwrite(2, 5, 12'h333);
        hwrite(3, 5, 12'h444);
        hread(2, 5);
        chk("hread_lane2", {rdata, rvalid}, {12'h333, 1'b1});
        tick();
        chk("hread_pulse_hold", {rdata, rvalid}, {12'h333, 1'b0});

        start = 1; mem_addr = 12'h005;
        tick();
        start = 0;
        chk("run_entry", {running, ready}, 2'b10);
        tick();
        chk("run_read5", pdi, {12'h444, 12'h333, 12'h222, 12'h111});
        chk("run_wrc0", wrc, 0);

        mem_addr = 12'h105; we = 1; pdo = {12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD};
        tick();
        chk("rbw_old_data", pdi, {12'h444, 12'h333, 12'h222, 12'h111});
        chk("wrc_one", wrc, 1);
        we = 0; mem_addr = 12'h005;
        tick();
        chk("wrap_new_data", pdi, {12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD});

        done = 1; start = 1;
        tick();
        done = 0; start = 0;
        chk("done_wins", {running, ready}, 2'b01);
        chk("wrc_hold", wrc, 1);
        we = 1; mem_addr = 12'h005; pdo = {4{12'h123}};
        tick();
        we = 0;
        chk("host_pdi_hold", pdi, {12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD});
        chk("host_wrc_hold", wrc, 1);
        hread(0, 5);
        chk("host_we_ignored_l0", rdata, 12'hDDD);
        hread(3, 5);
        chk("host_we_ignored_l3", rdata, 12'hAAA);

        hwrite(0, 7, 12'h010);
        hwrite(1, 7, 12'h020);
        hwrite(2, 7, 12'h030);
        hwrite(3, 7, 12'h777);
        hread(3, 7);
        chk("oor_read_zero", {rdata3, rvalid3}, {12'h000, 1'b1});
        chk("lane3_exists", {rdata, rvalid}, {12'h777, 1'b1});
        hread(0, 7);
        chk("oor_keep_l0", rdata3, 12'h010);
        hread(1, 7);
        chk("oor_keep_l1", rdata3, 12'h020);
        hread(2, 7);
        chk("oor_keep_l2", rdata3, 12'h030);

        start = 1;
        tick();
        start = 0;
        chk("rerun_wrc_clear", {running, wrc}, {1'b1, 16'd0});
        we = 1;
        mem_addr = 12'h00A; pdo = {12'h503, 12'h502, 12'h501, 12'h500};
        tick();
        mem_addr = 12'h00B; pdo = {12'h613, 12'h612, 12'h611, 12'h610};
        tick();
        mem_addr = 12'h00C; pdo = {12'h723, 12'h722, 12'h721, 12'h720};
        tick();
        chk("three_writes", wrc, 3);
        mem_addr = 12'h00D;
        #2 reset = 1;
        #1;
        chk("async_rst_running", running, 0);
        chk("async_rst_wrc", wrc, 0);
        chk("async_rst_pdi", pdi, 0);
        #2 reset = 0; we = 0;
        tick();
        hread(1, 11);
        chk("retained_l1_b", rdata, 12'h611);
        hread(3, 12);
        chk("retained_l3_c", rdata, 12'h723);
        hread(0, 10);
        chk("retained_l0_a", rdata, 12'h500);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
